// File: rtl/branch_resolve_btb.sv
// ---------------------------------------------------------------------------
// branch_resolve_btb
//
// Execute-stage branch/jump resolution together with the 4-entry branch
// target buffer that produced the fetch-time prediction. Fetch-side lookup
// and execute-side training live in one block so that the slot index carried
// down the pipe (branch_numberF -> branch_numberE) always refers to the same
// storage.
//
// Ports
//   CLK, NRST        clock (rising edge) / asynchronous active-low reset
//   pcF              fetch PC looked up in the BTB
//   predict_takenF   BTB hit with a taken-leaning counter
//   predict_targetF  target of the hit entry, 0 on miss
//   branch_numberF   hit slot, or replacement pointer on miss
//   branch_numberE   slot index carried from fetch for the E-stage instr
//   pcEj, immEj      E-stage PC and sign-extended offset
//   jump_codeEj      00 none, 01 JAL, 10 JALR, 11 none
//   branch_codeEj    001 BEQ .. 110 BGEU, 000/111 none
//   predict_takenE   prediction carried from fetch
//   predict_targetE  predicted target carried from fetch
//   rs1E, rs2E       forwarded operands
//   fail_predict     misprediction (combinational)
//   redirect_pc      correct next PC, 0 when the E-stage slot is a bubble
// ---------------------------------------------------------------------------
module branch_resolve_btb #(
  parameter int PC_W   = 13,
  parameter int DATA_W = 32,
  parameter int NENT   = 4
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic [PC_W-1:0]   pcF,
  output logic              predict_takenF,
  output logic [PC_W-1:0]   predict_targetF,
  output logic [1:0]        branch_numberF,
  input  logic [1:0]        branch_numberE,
  input  logic [PC_W-1:0]   pcEj,
  input  logic [PC_W-1:0]   immEj,
  input  logic [1:0]        jump_codeEj,
  input  logic [2:0]        branch_codeEj,
  input  logic              predict_takenE,
  input  logic [PC_W-1:0]   predict_targetE,
  input  logic [DATA_W-1:0] rs1E,
  input  logic [DATA_W-1:0] rs2E,
  output logic              fail_predict,
  output logic [PC_W-1:0]   redirect_pc
);

  // BTB state
  logic            valid_q  [NENT];
  logic            valid_d  [NENT];
  logic [PC_W-1:0] tag_q    [NENT];
  logic [PC_W-1:0] tag_d    [NENT];
  logic [PC_W-1:0] target_q [NENT];
  logic [PC_W-1:0] target_d [NENT];
  logic [1:0]      ctr_q    [NENT];
  logic [1:0]      ctr_d    [NENT];
  logic [1:0]      rptr_q;
  logic [1:0]      rptr_d;

  // ---------------------------------------------------------------------
  // Fetch lookup
  // ---------------------------------------------------------------------
  logic       hit;
  logic [1:0] hit_idx;

  // Scan from the top down so the lowest matching index is the one kept.
  always_comb begin
    hit     = 1'b0;
    hit_idx = rptr_q;
    for (int i = NENT - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == pcF)) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
    end
  end

  assign branch_numberF  = hit_idx;
  assign predict_takenF  = hit & ctr_q[hit_idx][1];
  assign predict_targetF = hit ? target_q[hit_idx] : '0;

  // ---------------------------------------------------------------------
  // Execute resolution
  // ---------------------------------------------------------------------
  logic                     is_jal;
  logic                     is_jalr;
  logic                     is_jump;
  logic                     is_br;
  logic                     active;
  logic                     br_taken;
  logic                     taken;
  logic signed [DATA_W-1:0] rs1_s;
  logic signed [DATA_W-1:0] rs2_s;
  logic [PC_W-1:0]          pc_imm;
  logic [PC_W-1:0]          jalr_sum;
  logic [PC_W-1:0]          tgt;
  logic [PC_W-1:0]          fall;

  assign is_jal  = (jump_codeEj == 2'b01);
  assign is_jalr = (jump_codeEj == 2'b10);
  assign is_jump = is_jal | is_jalr;
  assign is_br   = (branch_codeEj != 3'b000) && (branch_codeEj != 3'b111);
  assign active  = is_jump | is_br;

  assign rs1_s = rs1E;
  assign rs2_s = rs2E;

  always_comb begin
    br_taken = 1'b0;
    case (branch_codeEj)
      3'b001:  br_taken = (rs1E == rs2E);
      3'b010:  br_taken = (rs1E != rs2E);
      3'b011:  br_taken = (rs1_s <  rs2_s);
      3'b100:  br_taken = (rs1_s >= rs2_s);
      3'b101:  br_taken = (rs1E  <  rs2E);
      3'b110:  br_taken = (rs1E  >= rs2E);
      default: br_taken = 1'b0;
    endcase
  end

  // A valid jump code overrides any branch code in the same slot.
  assign taken = is_jump | (is_br & br_taken);

  // All sums are PC_W wide, so they wrap naturally.
  assign pc_imm   = pcEj + immEj;
  assign jalr_sum = rs1E[PC_W-1:0] + immEj;
  assign tgt      = is_jalr ? (jalr_sum & ~PC_W'(1)) : pc_imm;
  assign fall     = pcEj + PC_W'(4);

  assign fail_predict = active &
                        (taken ? !(predict_takenE && (predict_targetE == tgt))
                               : predict_takenE);
  assign redirect_pc  = !active ? '0 : (taken ? tgt : fall);

  // ---------------------------------------------------------------------
  // BTB training
  // ---------------------------------------------------------------------
  logic e_hit;

  // The slot index comes from fetch; the entry may have been replaced
  // since, so the tag is rechecked before training it.
  assign e_hit = valid_q[branch_numberE] && (tag_q[branch_numberE] == pcEj);

  always_comb begin
    for (int i = 0; i < NENT; i++) begin
      valid_d[i]  = valid_q[i];
      tag_d[i]    = tag_q[i];
      target_d[i] = target_q[i];
      ctr_d[i]    = ctr_q[i];
    end
    rptr_d = rptr_q;

    if (active) begin
      if (e_hit) begin
        if (taken) begin
          if (ctr_q[branch_numberE] != 2'b11) begin
            ctr_d[branch_numberE] = ctr_q[branch_numberE] + 2'b01;
          end
          target_d[branch_numberE] = tgt;
        end else if (ctr_q[branch_numberE] != 2'b00) begin
          ctr_d[branch_numberE] = ctr_q[branch_numberE] - 2'b01;
        end
      end else if (taken) begin
        // New entries start weakly taken.
        valid_d[branch_numberE]  = 1'b1;
        tag_d[branch_numberE]    = pcEj;
        target_d[branch_numberE] = tgt;
        ctr_d[branch_numberE]    = 2'b10;
        rptr_d                   = rptr_q + 2'b01;
      end
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      for (int i = 0; i < NENT; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b00;
      end
      rptr_q <= 2'b00;
    end else begin
      for (int i = 0; i < NENT; i++) begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        ctr_q[i]    <= ctr_d[i];
      end
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_btb.sv
module tb_branch_resolve_btb;

  localparam int PC_W   = 13;
  localparam int DATA_W = 32;
  localparam int PCMOD  = 8192;

  logic              CLK = 1'b0;
  logic              NRST;
  logic [PC_W-1:0]   pcF;
  logic              predict_takenF;
  logic [PC_W-1:0]   predict_targetF;
  logic [1:0]        branch_numberF;
  logic [1:0]        branch_numberE;
  logic [PC_W-1:0]   pcEj;
  logic [PC_W-1:0]   immEj;
  logic [1:0]        jump_codeEj;
  logic [2:0]        branch_codeEj;
  logic              predict_takenE;
  logic [PC_W-1:0]   predict_targetE;
  logic [DATA_W-1:0] rs1E;
  logic [DATA_W-1:0] rs2E;
  logic              fail_predict;
  logic [PC_W-1:0]   redirect_pc;

  branch_resolve_btb #(.PC_W(PC_W), .DATA_W(DATA_W), .NENT(4)) dut (
    .CLK(CLK), .NRST(NRST), .pcF(pcF),
    .predict_takenF(predict_takenF), .predict_targetF(predict_targetF),
    .branch_numberF(branch_numberF), .branch_numberE(branch_numberE),
    .pcEj(pcEj), .immEj(immEj), .jump_codeEj(jump_codeEj),
    .branch_codeEj(branch_codeEj), .predict_takenE(predict_takenE),
    .predict_targetE(predict_targetE), .rs1E(rs1E), .rs2E(rs2E),
    .fail_predict(fail_predict), .redirect_pc(redirect_pc)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Behavioural model: table of entries, integer arithmetic mod 2**13
  // ------------------------------------------------------------------
  bit mv   [4];
  int mtag [4];
  int mtgt [4];
  int mctr [4];
  int mrptr;

  function automatic void mresolve(output bit act, output bit tk, output int tgt);
    bit jmp;
    bit br;
    jmp = (jump_codeEj == 2'd1) || (jump_codeEj == 2'd2);
    br  = (branch_codeEj >= 3'd1) && (branch_codeEj <= 3'd6);
    act = jmp || br;
    tgt = (int'(pcEj) + int'(immEj)) % PCMOD;
    if (jump_codeEj == 2'd2) begin
      tgt = (int'(rs1E[PC_W-1:0]) + int'(immEj)) % PCMOD;
      tgt = tgt - (tgt % 2);
    end
    tk = 1'b0;
    if (jmp) tk = 1'b1;
    else if (br) begin
      case (branch_codeEj)
        3'd1: tk = (rs1E == rs2E);
        3'd2: tk = (rs1E != rs2E);
        3'd3: tk = ($signed(rs1E) <  $signed(rs2E));
        3'd4: tk = ($signed(rs1E) >= $signed(rs2E));
        3'd5: tk = (rs1E <  rs2E);
        default: tk = (rs1E >= rs2E);
      endcase
    end
  endfunction

  always @(posedge CLK or negedge NRST) begin
    bit a, t;
    int g, b;
    if (!NRST) begin
      for (int i = 0; i < 4; i++) begin
        mv[i] = 1'b0; mtag[i] = 0; mtgt[i] = 0; mctr[i] = 0;
      end
      mrptr = 0;
    end else begin
      mresolve(a, t, g);
      b = int'(branch_numberE);
      if (a) begin
        if (mv[b] && mtag[b] == int'(pcEj)) begin
          if (t) begin
            mctr[b] = (mctr[b] < 3) ? mctr[b] + 1 : 3;
            mtgt[b] = g;
          end else begin
            mctr[b] = (mctr[b] > 0) ? mctr[b] - 1 : 0;
          end
        end else if (t) begin
          mv[b] = 1'b1; mtag[b] = int'(pcEj); mtgt[b] = g; mctr[b] = 2;
          mrptr = (mrptr + 1) % 4;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge CLK) begin
    bit a, t, hit, efail;
    int g, ered, hi;
    mresolve(a, t, g);
    ered  = !a ? 0 : (t ? g : (int'(pcEj) + 4) % PCMOD);
    efail = a && (t ? !(predict_takenE && int'(predict_targetE) == g) : predict_takenE);
    hit = 1'b0;
    hi  = mrptr;
    for (int i = 3; i >= 0; i--) begin
      if (mv[i] && mtag[i] == int'(pcF)) begin
        hit = 1'b1;
        hi  = i;
      end
    end
    chk("m_fail_predict", 32'(fail_predict), 32'(efail));
    chk("m_redirect_pc", 32'(redirect_pc), 32'(ered));
    chk("m_predict_takenF", 32'(predict_takenF), 32'(hit && mctr[hi] >= 2));
    chk("m_predict_targetF", 32'(predict_targetF), hit ? 32'(mtgt[hi]) : 32'd0);
    chk("m_branch_numberF", 32'(branch_numberF), 32'(hi));
  end

  // ------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // ------------------------------------------------------------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv(input logic [1:0] bn, input logic [12:0] pc, input logic [12:0] imm,
                     input logic [1:0] jc, input logic [2:0] bc, input logic pt,
                     input logic [12:0] ptg, input logic [31:0] r1, input logic [31:0] r2);
    branch_numberE  = bn;
    pcEj            = pc;
    immEj           = imm;
    jump_codeEj     = jc;
    branch_codeEj   = bc;
    predict_takenE  = pt;
    predict_targetE = ptg;
    rs1E            = r1;
    rs2E            = r2;
  endtask

  task automatic idle();
    drv(2'd0, 13'h0, 13'h0, 2'b00, 3'b000, 1'b0, 13'h0, 32'h0, 32'h0);
  endtask

  initial begin
    NRST = 1'b0;
    pcF  = 13'h0;
    idle();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_predict_takenF", 32'(predict_takenF), 32'd0);
    chk("rst_predict_targetF", 32'(predict_targetF), 32'd0);
    chk("rst_branch_numberF", 32'(branch_numberF), 32'd0);
    chk("rst_fail_predict", 32'(fail_predict), 32'd0);
    NRST = 1'b1;

    // Test 1: first taken BEQ allocates slot 0
    pcF = 13'h040;
    drv(2'd0, 13'h040, 13'h020, 2'b00, 3'b001, 1'b0, 13'h0, 32'd5, 32'd5);
    #2;
    chk("t1_miss_ptaken", 32'(predict_takenF), 32'd0);
    chk("t1_miss_bnum", 32'(branch_numberF), 32'd0);
    chk("t1_fail", 32'(fail_predict), 32'd1);
    chk("t1_redirect", 32'(redirect_pc), 32'h060);
    step(); idle(); #2;
    chk("t1_hit_ptaken", 32'(predict_takenF), 32'd1);
    chk("t1_hit_target", 32'(predict_targetF), 32'h060);
    chk("t1_hit_bnum", 32'(branch_numberF), 32'd0);
    pcF = 13'h100; #1;
    chk("t1_rptr", 32'(branch_numberF), 32'd1);

    // Test 2: counter training down
    step(); pcF = 13'h040;
    drv(2'd0, 13'h040, 13'h020, 2'b00, 3'b001, 1'b1, 13'h060, 32'd1, 32'd2);
    #2;
    chk("t2_fail1", 32'(fail_predict), 32'd1);
    chk("t2_redirect1", 32'(redirect_pc), 32'h044);
    step(); idle(); #2;
    chk("t2_ctr01_ptaken", 32'(predict_takenF), 32'd0);
    chk("t2_ctr01_bnum", 32'(branch_numberF), 32'd0);
    drv(2'd0, 13'h040, 13'h020, 2'b00, 3'b001, 1'b0, 13'h0, 32'd1, 32'd2);
    #1;
    chk("t2_fail2", 32'(fail_predict), 32'd0);
    step(); idle(); #2;
    chk("t2_ctr00_ptaken", 32'(predict_takenF), 32'd0);
    chk("t2_ctr00_bnum", 32'(branch_numberF), 32'd0);

    // Test 3: JALR with wrong target, then JAL
    drv(2'd0, 13'h040, 13'h004, 2'b10, 3'b000, 1'b1, 13'h0238, 32'h0000_1235, 32'h0);
    #1;
    chk("t3_jalr_fail", 32'(fail_predict), 32'd1);
    chk("t3_jalr_redirect", 32'(redirect_pc), 32'h1238);
    step(); idle(); #2;
    chk("t3_target_upd", 32'(predict_targetF), 32'h1238);
    chk("t3_ctr01_ptaken", 32'(predict_takenF), 32'd0);
    drv(2'd0, 13'h040, 13'h010, 2'b01, 3'b000, 1'b0, 13'h0, 32'h0, 32'h0);
    #1;
    chk("t3_jal_redirect", 32'(redirect_pc), 32'h050);
    step(); idle(); #2;
    chk("t3_jal_ptaken", 32'(predict_takenF), 32'd1);
    chk("t3_jal_target", 32'(predict_targetF), 32'h050);

    // Test 4: wrap-around arithmetic
    drv(2'd1, 13'h1FFC, 13'h020, 2'b00, 3'b010, 1'b0, 13'h0, 32'd7, 32'd7);
    #1;
    chk("t4_fall_wrap", 32'(redirect_pc), 32'h0000);
    chk("t4_fall_fail", 32'(fail_predict), 32'd0);
    step();
    drv(2'd1, 13'h1FF0, 13'h020, 2'b00, 3'b010, 1'b0, 13'h0, 32'd7, 32'd8);
    #1;
    chk("t4_tgt_wrap", 32'(redirect_pc), 32'h0010);
    step(); idle(); pcF = 13'h1FF0; #2;
    chk("t4_alloc_bnum", 32'(branch_numberF), 32'd1);
    chk("t4_alloc_target", 32'(predict_targetF), 32'h0010);

    // Jump precedence over a not-taken branch code, and reserved codes
    drv(2'd2, 13'h100, 13'h040, 2'b01, 3'b001, 1'b1, 13'h140, 32'd1, 32'd2);
    #1;
    chk("prec_redirect", 32'(redirect_pc), 32'h140);
    chk("prec_fail", 32'(fail_predict), 32'd0);
    step();
    drv(2'd0, 13'h200, 13'h040, 2'b11, 3'b111, 1'b1, 13'h240, 32'd1, 32'd1);
    #1;
    chk("none_fail", 32'(fail_predict), 32'd0);
    chk("none_redirect", 32'(redirect_pc), 32'h0);
    step();

    // Test 5: round-robin replacement after a reset pulse
    NRST = 1'b0; idle(); #1; NRST = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pcF = 13'(13'h200 + 16 * k);
      #1;
      chk("t5_slot", 32'(branch_numberF), 32'(k % 4));
      drv(2'(k % 4), 13'(13'h200 + 16 * k), 13'h100, 2'b01, 3'b000, 1'b0, 13'h0, 32'h0, 32'h0);
      step();
    end
    idle(); pcF = 13'h200; #2;
    chk("t5_evicted_ptaken", 32'(predict_takenF), 32'd0);
    chk("t5_evicted_bnum", 32'(branch_numberF), 32'd1);
    pcF = 13'h240; #1;
    chk("t5_new_bnum", 32'(branch_numberF), 32'd0);
    chk("t5_new_target", 32'(predict_targetF), 32'h340);

    // Test 6: signed vs unsigned compares, then mid-run reset
    step();
    drv(2'd1, 13'h300, 13'h008, 2'b00, 3'b011, 1'b1, 13'h308, 32'hFFFF_FFFF, 32'd1);
    #1;
    chk("t6_blt_fail", 32'(fail_predict), 32'd0);
    chk("t6_blt_redirect", 32'(redirect_pc), 32'h308);
    step();
    drv(2'd2, 13'h300, 13'h008, 2'b00, 3'b101, 1'b0, 13'h0, 32'hFFFF_FFFF, 32'd1);
    #1;
    chk("t6_bltu_redirect", 32'(redirect_pc), 32'h304);
    step();
    drv(2'd2, 13'h300, 13'h008, 2'b00, 3'b100, 1'b1, 13'h308, 32'hFFFF_FFFF, 32'd1);
    #1;
    chk("t6_bge_fail", 32'(fail_predict), 32'd1);
    step();
    drv(2'd2, 13'h300, 13'h008, 2'b00, 3'b110, 1'b0, 13'h0, 32'hFFFF_FFFF, 32'd1);
    #1;
    chk("t6_bgeu_redirect", 32'(redirect_pc), 32'h308);
    step(); idle(); pcF = 13'h240; #2;
    chk("t6_pre_rst_ptaken", 32'(predict_takenF), 32'd1);
    NRST = 1'b0; #1;
    chk("t6_rst_ptaken", 32'(predict_takenF), 32'd0);
    chk("t6_rst_target", 32'(predict_targetF), 32'd0);
    chk("t6_rst_bnum", 32'(branch_numberF), 32'd0);
    step();
    NRST = 1'b1; pcF = 13'h300; #1;
    chk("t6_after_rst_ptaken", 32'(predict_takenF), 32'd0);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
